// File: rtl/eth_phy_10g_pcs.sv
// 10GBASE-R PCS: 64b/66b encode/decode between XGMII and a 66b SERDES,
// optional self-synchronous scrambling, block lock with bitslip and BER monitor.
module eth_phy_10g_pcs #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int HDR_WIDTH           = 2,
    parameter bit BIT_REVERSE         = 1'b0,
    parameter bit SCRAMBLER_DISABLE   = 1'b1,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int COUNT_125US         = 19531
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xgmii_txd,
    input  logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic [DATA_WIDTH-1:0] xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] xgmii_rxc,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_bitslip,
    output logic [6:0]            rx_error_count,
    output logic                  rx_bad_block,
    output logic                  rx_block_lock,
    output logic                  rx_high_ber
);
    localparam logic [1:0]      SYNC_DATA = 2'b10;
    localparam logic [1:0]      SYNC_CTRL = 2'b01;
    localparam logic [63:0]     IDLE_WORD = {8{8'h07}};
    localparam logic [63:0]     ERR_WORD  = {8{8'hFE}};
    localparam logic [63:0]     ERR_BLOCK = {{8{7'h1E}}, 8'h1E};
    // Terminate block type indexed by the lane holding /T/.
    localparam logic [7:0][7:0] TERM_TYPE = {8'hFF, 8'hE1, 8'hD2, 8'hCC,
                                             8'hB4, 8'hAA, 8'h99, 8'h87};
    localparam int BW = $clog2(COUNT_125US);

    typedef enum logic [1:0] {ST_UNLOCK, ST_SLIP, ST_WAIT, ST_LOCK} lock_state_t;

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic ctl_ok(input logic [6:0] c);
        return (c == 7'h00) || (c == 7'h1E);
    endfunction

    function automatic logic [7:0] ctl_char(input logic [6:0] c);
        return (c == 7'h00) ? 8'h07 : 8'hFE;
    endfunction

    logic [63:0] tx_enc, tx_scr, tx_keep, rx_pl, rx_dscr, rx_blk, rx_keep, rx_dec_d;
    logic [57:0] scr_state, scr_state_n, dscr_state, dscr_state_n;
    logic [7:0]  rx_dec_c;
    logic [1:0]  tx_enc_hdr, rx_hdr_i;
    logic        term_hit, rx_dec_bad, codes_ok, rx_hdr_ok, b;
    lock_state_t lock_state, lock_state_n;
    logic [5:0]  sh_cnt, sh_cnt_n, win_cnt, win_cnt_n;
    logic [4:0]  inv_cnt, inv_cnt_n;
    logic [15:0] slip_cnt, slip_cnt_n;
    logic [BW-1:0] ber_win;
    logic [6:0]  err_cnt_n;

    // TX encode: classify the XGMII word and build the 66b block.
    always_comb begin
        tx_enc_hdr = SYNC_CTRL;
        tx_enc     = ERR_BLOCK;
        tx_keep    = '0;
        term_hit   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (xgmii_txc == (8'hFF << k) && xgmii_txd[8*k +: 8] == 8'hFD) begin
                term_hit = 1'b1;
                tx_keep  = xgmii_txd & ~({64{1'b1}} << (8*k));
                tx_enc   = {tx_keep[55:0], TERM_TYPE[k]};
            end
        end
        if (xgmii_txc == 8'h00) begin
            tx_enc_hdr = SYNC_DATA;
            tx_enc     = xgmii_txd;
        end else if (xgmii_txc == 8'h01 && xgmii_txd[7:0] == 8'hFB) begin
            tx_enc = {xgmii_txd[63:8], 8'h78};
        end else if (xgmii_txc == 8'h1F && xgmii_txd[39:0] == {8'hFB, 32'h07070707}) begin
            tx_enc = {xgmii_txd[63:40], 32'h0, 8'h33};
        end else if (!term_hit && xgmii_txc == 8'hFF) begin
            tx_enc[7:0] = 8'h1E;
            for (int i = 0; i < 8; i++)
                tx_enc[8+7*i +: 7] = (xgmii_txd[8*i +: 8] == 8'h07) ? 7'h00 : 7'h1E;
        end else if (!term_hit) begin
            tx_enc = ERR_BLOCK;
        end
    end

    // Scrambler x^58+x^39+1, LSB first; scrambled bits feed back into the state.
    always_comb begin
        scr_state_n = scr_state;
        tx_scr      = tx_enc;
        for (int i = 0; i < 64; i++) begin
            b           = tx_enc[i] ^ scr_state_n[38] ^ scr_state_n[57];
            tx_scr[i]   = b;
            scr_state_n = {scr_state_n[56:0], b};
        end
    end

    // TX output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            serdes_tx_hdr  <= SYNC_CTRL;
            serdes_tx_data <= 64'h1E;
            scr_state      <= '0;
        end else begin
            serdes_tx_hdr  <= BIT_REVERSE ? {tx_enc_hdr[0], tx_enc_hdr[1]} : tx_enc_hdr;
            serdes_tx_data <= BIT_REVERSE ? rev64(SCRAMBLER_DISABLE ? tx_enc : tx_scr)
                                          : (SCRAMBLER_DISABLE ? tx_enc : tx_scr);
            scr_state      <= scr_state_n;
        end
    end

    assign rx_pl     = BIT_REVERSE ? rev64(serdes_rx_data) : serdes_rx_data;
    assign rx_hdr_i  = BIT_REVERSE ? {serdes_rx_hdr[0], serdes_rx_hdr[1]} : serdes_rx_hdr;
    assign rx_hdr_ok = rx_hdr_i[0] ^ rx_hdr_i[1];
    assign rx_blk    = SCRAMBLER_DISABLE ? rx_pl : rx_dscr;

    // Descrambler: received (scrambled) bits feed the state, so it self-synchronises.
    always_comb begin
        dscr_state_n = dscr_state;
        rx_dscr      = rx_pl;
        for (int i = 0; i < 64; i++) begin
            rx_dscr[i]   = rx_pl[i] ^ dscr_state_n[38] ^ dscr_state_n[57];
            dscr_state_n = {dscr_state_n[56:0], rx_pl[i]};
        end
    end

    // RX decode: anything not recognised collapses to an all-/E/ word.
    always_comb begin
        rx_dec_d   = ERR_WORD;
        rx_dec_c   = 8'hFF;
        rx_dec_bad = 1'b1;
        codes_ok   = 1'b1;
        rx_keep    = '0;
        if (rx_hdr_i == SYNC_DATA) begin
            rx_dec_d   = rx_blk;
            rx_dec_c   = 8'h00;
            rx_dec_bad = 1'b0;
        end else if (rx_hdr_i == SYNC_CTRL) begin
            if (rx_blk[7:0] == 8'h78) begin
                rx_dec_d   = {rx_blk[63:8], 8'hFB};
                rx_dec_c   = 8'h01;
                rx_dec_bad = 1'b0;
            end else if (rx_blk[7:0] == 8'h33) begin
                for (int i = 0; i < 4; i++) codes_ok &= ctl_ok(rx_blk[8+7*i +: 7]);
                if (codes_ok && rx_blk[39:36] == 4'h0) begin
                    rx_dec_d   = {rx_blk[63:40], 8'hFB, ctl_char(rx_blk[29 +: 7]),
                                  ctl_char(rx_blk[22 +: 7]), ctl_char(rx_blk[15 +: 7]),
                                  ctl_char(rx_blk[8 +: 7])};
                    rx_dec_c   = 8'h1F;
                    rx_dec_bad = 1'b0;
                end
            end else if (rx_blk[7:0] == 8'h1E) begin
                for (int i = 0; i < 8; i++) begin
                    codes_ok &= ctl_ok(rx_blk[8+7*i +: 7]);
                    rx_dec_d[8*i +: 8] = ctl_char(rx_blk[8+7*i +: 7]);
                end
                if (codes_ok) rx_dec_bad = 1'b0;
                else          rx_dec_d   = ERR_WORD;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (rx_blk[7:0] == TERM_TYPE[k]) begin
                        rx_keep            = ~({64{1'b1}} << (8*k));
                        rx_dec_d           = ({8'h00, rx_blk[63:8]} & rx_keep) | (IDLE_WORD & ~rx_keep);
                        rx_dec_d[8*k +: 8] = 8'hFD;
                        rx_dec_c           = 8'hFF << k;
                        rx_dec_bad         = 1'b0;
                    end
                end
            end
        end
    end

    // RX output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            xgmii_rxd    <= IDLE_WORD;
            xgmii_rxc    <= 8'hFF;
            rx_bad_block <= 1'b0;
            dscr_state   <= '0;
        end else begin
            xgmii_rxd    <= rx_dec_d;
            xgmii_rxc    <= rx_dec_c;
            rx_bad_block <= rx_dec_bad;
            dscr_state   <= dscr_state_n;
        end
    end

    // Block lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= ST_UNLOCK;
            sh_cnt     <= '0;
            slip_cnt   <= '0;
            win_cnt    <= '0;
            inv_cnt    <= '0;
        end else begin
            lock_state <= lock_state_n;
            sh_cnt     <= sh_cnt_n;
            slip_cnt   <= slip_cnt_n;
            win_cnt    <= win_cnt_n;
            inv_cnt    <= inv_cnt_n;
        end
    end

    // Block lock next state: hunt for 64 good headers, slip on any bad one while
    // hunting; once locked, 16 bad headers in a 64-header window drop lock.
    always_comb begin
        lock_state_n = lock_state;
        sh_cnt_n     = sh_cnt;
        slip_cnt_n   = slip_cnt;
        win_cnt_n    = win_cnt;
        inv_cnt_n    = inv_cnt;
        case (lock_state)
            ST_UNLOCK: begin
                if (!rx_hdr_ok) begin
                    lock_state_n = ST_SLIP;
                    slip_cnt_n   = '0;
                end else if (sh_cnt == 6'd63) begin
                    lock_state_n = ST_LOCK;
                    win_cnt_n    = '0;
                    inv_cnt_n    = '0;
                end else begin
                    sh_cnt_n = sh_cnt + 6'd1;
                end
            end
            ST_SLIP: begin
                if (slip_cnt == 16'(BITSLIP_HIGH_CYCLES - 1)) begin
                    lock_state_n = ST_WAIT;
                    slip_cnt_n   = '0;
                end else begin
                    slip_cnt_n = slip_cnt + 16'd1;
                end
            end
            ST_WAIT: begin
                if (slip_cnt == 16'(BITSLIP_LOW_CYCLES - 1)) begin
                    lock_state_n = ST_UNLOCK;
                    sh_cnt_n     = '0;
                end else begin
                    slip_cnt_n = slip_cnt + 16'd1;
                end
            end
            ST_LOCK: begin
                win_cnt_n = win_cnt + 6'd1;
                inv_cnt_n = inv_cnt + {4'd0, !rx_hdr_ok};
                if (!rx_hdr_ok && inv_cnt == 5'd15) begin
                    lock_state_n = ST_SLIP;
                    slip_cnt_n   = '0;
                end else if (win_cnt == 6'd63) begin
                    inv_cnt_n = '0;
                end
            end
            default: lock_state_n = ST_UNLOCK;
        endcase
    end

    assign rx_block_lock     = (lock_state == ST_LOCK);
    assign serdes_rx_bitslip = (lock_state == ST_SLIP);
    assign err_cnt_n = (!rx_hdr_ok && rx_error_count != 7'h7F) ? rx_error_count + 7'd1
                                                               : rx_error_count;

    // BER monitor: saturating error count per free-running window.
    always_ff @(posedge clk) begin
        if (rst) begin
            ber_win        <= '0;
            rx_error_count <= '0;
            rx_high_ber    <= 1'b0;
        end else if (ber_win == BW'(COUNT_125US - 1)) begin
            ber_win        <= '0;
            rx_error_count <= '0;
            rx_high_ber    <= (err_cnt_n >= 7'd16);
        end else begin
            ber_win        <= ber_win + 1'b1;
            rx_error_count <= err_cnt_n;
            if (err_cnt_n >= 7'd16) rx_high_ber <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eth_phy_10g_pcs.sv
// Directed + randomized bench for eth_phy_10g_pcs: encode/decode against a
// behavioural block model, lock/bitslip and BER sequences, and a scrambled,
// bit-reversed loopback instance.
module tb_eth_phy_10g_pcs;
    localparam int W = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] xgmii_txd, xgmii_rxd, serdes_tx_data, serdes_rx_data;
    logic [7:0]  xgmii_txc, xgmii_rxc;
    logic [1:0]  serdes_tx_hdr, serdes_rx_hdr;
    logic        serdes_rx_bitslip, rx_bad_block, rx_block_lock, rx_high_ber;
    logic [6:0]  rx_error_count;

    logic [63:0] l_txd, l_rxd, l_tx_data;
    logic [7:0]  l_txc, l_rxc;
    logic [1:0]  l_tx_hdr;
    logic        l_bitslip, l_bad, l_lock, l_hber;
    logic [6:0]  l_err;

    eth_phy_10g_pcs #(.COUNT_125US(W)) dut (
        .clk(clk), .rst(rst),
        .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
        .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .serdes_tx_data(serdes_tx_data), .serdes_tx_hdr(serdes_tx_hdr),
        .serdes_rx_data(serdes_rx_data), .serdes_rx_hdr(serdes_rx_hdr),
        .serdes_rx_bitslip(serdes_rx_bitslip), .rx_error_count(rx_error_count),
        .rx_bad_block(rx_bad_block), .rx_block_lock(rx_block_lock),
        .rx_high_ber(rx_high_ber)
    );

    // Loopback instance: scrambler on, bit reversal on, TX wired to RX.
    eth_phy_10g_pcs #(.COUNT_125US(W), .BIT_REVERSE(1), .SCRAMBLER_DISABLE(0)) dut2 (
        .clk(clk), .rst(rst),
        .xgmii_txd(l_txd), .xgmii_txc(l_txc),
        .xgmii_rxd(l_rxd), .xgmii_rxc(l_rxc),
        .serdes_tx_data(l_tx_data), .serdes_tx_hdr(l_tx_hdr),
        .serdes_rx_data(l_tx_data), .serdes_rx_hdr(l_tx_hdr),
        .serdes_rx_bitslip(l_bitslip), .rx_error_count(l_err),
        .rx_bad_block(l_bad), .rx_block_lock(l_lock), .rx_high_ber(l_hber)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Reference 64b/66b encoder written from the block-format rules.
    function automatic logic [65:0] model_enc(input logic [63:0] d, input logic [7:0] c);
        logic [7:0]  by [8];
        logic [7:0]  tt [8];
        logic [63:0] p;
        logic [65:0] r;
        logic [7:0]  ones;
        logic        done;
        tt   = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        ones = 8'hFF;
        p    = '0;
        done = 1'b0;
        r    = {2'b01, {8{7'h1E}}, 8'h1E};
        for (int i = 0; i < 8; i++) by[i] = d[8*i +: 8];
        if (c == 8'h00) begin
            r = {2'b10, d}; done = 1'b1;
        end else if (c == 8'h01 && by[0] == 8'hFB) begin
            r = {2'b01, d[63:8], 8'h78}; done = 1'b1;
        end else if (c == 8'h1F && by[4] == 8'hFB && by[0] == 8'h07 && by[1] == 8'h07
                     && by[2] == 8'h07 && by[3] == 8'h07) begin
            r = {2'b01, d[63:40], 32'h0, 8'h33}; done = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            if (!done && c == 8'(ones << k) && by[k] == 8'hFD) begin
                for (int j = 0; j < k; j++) p[8+8*j +: 8] = by[j];
                p[7:0] = tt[k];
                r = {2'b01, p};
                done = 1'b1;
            end
        end
        if (!done && c == 8'hFF) begin
            p[7:0] = 8'h1E;
            for (int i = 0; i < 8; i++) p[8+7*i +: 7] = (by[i] == 8'h07) ? 7'h00 : 7'h1E;
            r = {2'b01, p};
        end
        return r;
    endfunction

    // Random well-formed XGMII word: data, start (lane 0/4), terminate, idle.
    task automatic gen_valid(output logic [63:0] d, output logic [7:0] c);
        int kind;
        int k;
        logic [7:0] ones;
        ones = 8'hFF;
        kind = $urandom_range(0, 4);
        d = {$urandom, $urandom};
        c = 8'h00;
        case (kind)
            1: begin d[7:0] = 8'hFB; c = 8'h01; end
            2: begin d[39:0] = {8'hFB, 32'h07070707}; c = 8'h1F; end
            3: begin
                k = $urandom_range(0, 7);
                c = ones << k;
                for (int j = 0; j < 8; j++)
                    if (j >= k) d[8*j +: 8] = (j == k) ? 8'hFD : 8'h07;
            end
            4: begin d = {8{8'h07}}; c = 8'hFF; end
            default: ;
        endcase
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " tx_hdr"}, serdes_tx_hdr, 2'b01);
        check({tag, " tx_data"}, serdes_tx_data, 64'h1E);
        check({tag, " rxd"}, xgmii_rxd, 64'h0707070707070707);
        check({tag, " rxc"}, xgmii_rxc, 8'hFF);
        check({tag, " flags"}, {rx_bad_block, rx_block_lock, serdes_rx_bitslip, rx_high_ber, rx_error_count}, '0);
    endtask

    initial begin
        logic [63:0] d, d2;
        logic [7:0]  c, c2;
        logic [65:0] blk;
        logic [63:0] hist_d [$];
        logic [7:0]  hist_c [$];

        rst = 1'b1;
        xgmii_txd = {8{8'h07}}; xgmii_txc = 8'hFF;
        serdes_rx_hdr = 2'b01; serdes_rx_data = 64'h1E;
        l_txd = {8{8'h07}}; l_txc = 8'hFF;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // Directed encode/decode cases.
        xgmii_txd = 64'hd5555555555555fb; xgmii_txc = 8'h01;
        serdes_rx_hdr = 2'b01; serdes_rx_data = 64'haaaaaaaaaaaaaa78;
        tick();
        check("tx start", {serdes_tx_hdr, serdes_tx_data}, {2'b01, 64'hd555555555555578});
        check("rx start", {xgmii_rxc, xgmii_rxd}, {8'h01, 64'haaaaaaaaaaaaaafb});
        xgmii_txd = 64'h000dddddaaaddddd; xgmii_txc = 8'h00;
        serdes_rx_data = 64'h87;
        tick();
        check("tx data", {serdes_tx_hdr, serdes_tx_data}, {2'b10, 64'h000dddddaaaddddd});
        check("rx term0", {xgmii_rxc, xgmii_rxd}, {8'hFF, 64'h07070707070707fd});
        xgmii_txd = 64'hfd2233ee44eeefff; xgmii_txc = 8'h80;
        serdes_rx_data = 64'h1E;
        tick();
        check("tx term7", {serdes_tx_hdr, serdes_tx_data}, {2'b01, 64'h2233ee44eeefffff});
        check("rx idle", {rx_bad_block, xgmii_rxc, xgmii_rxd}, {1'b0, 8'hFF, 64'h0707070707070707});
        xgmii_txd = 64'h0123456789abcdef; xgmii_txc = 8'h0F;
        serdes_rx_hdr = 2'b11;
        tick();
        check("tx error", {serdes_tx_hdr, serdes_tx_data}, {2'b01, {8{7'h1E}}, 8'h1E});
        check("rx hdr11", {rx_bad_block, xgmii_rxc, xgmii_rxd}, {1'b1, 8'hFF, {8{8'hFE}}});
        serdes_rx_hdr = 2'b01; serdes_rx_data = 64'h55;
        tick();
        check("rx bad type", {rx_bad_block, xgmii_rxd}, {1'b1, {8{8'hFE}}});
        serdes_rx_data = {35'h0, 7'h2A, 14'h0, 8'h1E};
        tick();
        check("rx bad code", {rx_bad_block, xgmii_rxd}, {1'b1, {8{8'hFE}}});
        serdes_rx_data = 64'h1E;
        tick();
        check("rx bad pulse end", rx_bad_block, 1'b0);

        // Randomized TX against the encoder model, RX by round trip.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) gen_valid(d, c);
            else begin d = {$urandom, $urandom}; c = 8'($urandom); end
            gen_valid(d2, c2);
            blk = model_enc(d2, c2);
            xgmii_txd = d; xgmii_txc = c;
            serdes_rx_hdr = blk[65:64]; serdes_rx_data = blk[63:0];
            tick();
            check("tx rand", {serdes_tx_hdr, serdes_tx_data}, model_enc(d, c));
            check("rx rand", {rx_bad_block, xgmii_rxc, xgmii_rxd}, {1'b0, c2, d2});
        end

        // Reset in the middle of traffic.
        rst = 1'b1;
        tick();
        check_reset_vals("mid reset");
        rst = 1'b0;
        xgmii_txd = {8{8'h07}}; xgmii_txc = 8'hFF;

        // Unlocked slip: one bad header, one slip cycle, then 8 ignored headers.
        serdes_rx_hdr = 2'b01; serdes_rx_data = 64'h1E;
        repeat (5) tick();
        serdes_rx_hdr = 2'b00;
        tick();
        check("slip high", {serdes_rx_bitslip, rx_block_lock}, 2'b10);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("slip ignore", {serdes_rx_bitslip, rx_block_lock}, 2'b00);
        end
        tick();
        check("slip again", serdes_rx_bitslip, 1'b1);
        serdes_rx_hdr = 2'b10;
        for (int i = 1; i <= 73; i++) begin
            tick();
            check("lock acquire", rx_block_lock, (i == 73));
        end

        // Locked: bad headers split across two windows keep lock.
        serdes_rx_hdr = 2'b00; repeat (10) tick();
        serdes_rx_hdr = 2'b10; repeat (54) tick();
        serdes_rx_hdr = 2'b00; repeat (10) tick();
        check("lock window", rx_block_lock, 1'b1);
        serdes_rx_hdr = 2'b10; repeat (54) tick();
        serdes_rx_hdr = 2'b11; repeat (15) tick();
        check("lock 15 bad", {rx_block_lock, serdes_rx_bitslip}, 2'b10);
        tick();
        check("lock lost", {rx_block_lock, serdes_rx_bitslip}, 2'b01);

        // BER: 16 errors in window 0, clean window 1, saturation in window 2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        serdes_rx_data = 64'h1E;
        for (int e = 0; e <= 2*W + 140; e++) begin
            serdes_rx_hdr = ((e >= 10 && e <= 25) || (e >= 2*W + 5 && e < 2*W + 135)) ? 2'b00 : 2'b01;
            tick();
            if (e == 24)        check("ber 15", {rx_high_ber, rx_error_count}, {1'b0, 7'd15});
            if (e == 25)        check("ber 16", {rx_high_ber, rx_error_count}, {1'b1, 7'd16});
            if (e == W - 2)     check("ber win0 end-1", {rx_high_ber, rx_error_count}, {1'b1, 7'd16});
            if (e == W - 1)     check("ber win0 end", {rx_high_ber, rx_error_count}, {1'b1, 7'd0});
            if (e == 2*W - 1)   check("ber clean win", {rx_high_ber, rx_error_count}, {1'b0, 7'd0});
            if (e == 2*W + 130) check("ber 126", rx_error_count, 7'd126);
            if (e == 2*W + 140) check("ber sat", {rx_high_ber, rx_error_count}, {1'b1, 7'd127});
        end

        // Scrambled, bit-reversed loopback returns the XGMII stream.
        for (int i = 0; i < 300; i++) begin
            gen_valid(d, c);
            l_txd = d; l_txc = c;
            hist_d.push_back(d); hist_c.push_back(c);
            tick();
            if (i >= 2) begin
                check("loopback", {l_bad, l_rxc, l_rxd}, {1'b0, hist_c[i-1], hist_d[i-1]});
            end
        end
        check("loopback lock", {l_lock, l_hber}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eth_phy_10g_pcs.md
Name: eth_phy_10g_pcs

Overview:
Single-clock 10GBASE-R PCS core sitting between a 64-bit XGMII MAC interface and a 64b/66b SERDES (64-bit data plus 2-bit sync header).
- TX path: encodes XGMII into 66b blocks, with an optional scrambler.
- RX path: optional descrambler, then decodes 66b blocks back to XGMII.
- RX monitoring: block lock with bitslip, bad-block detection, high-BER detection.

Parameters:
DATA_WIDTH, 64, data path width; only 64 is supported.
CTRL_WIDTH, DATA_WIDTH/8, XGMII control width (8).
HDR_WIDTH, 2, sync header width; only 2 is supported.
BIT_REVERSE, 0, 1 = bit-reverse data and header at the SERDES side, both directions.
SCRAMBLER_DISABLE, 1, 1 = bypass the x^58+x^39+1 self-synchronous scrambler and descrambler.
BITSLIP_HIGH_CYCLES, 1, number of cycles serdes_rx_bitslip is held high per slip.
BITSLIP_LOW_CYCLES, 8, number of cycles invalid headers are ignored after a slip.
COUNT_125US, 19531, BER window length in cycles (125 us at 6.4 ns).

Ports:
clk  in  1  PCS clock, shared by TX and RX.
rst  in  1  synchronous active-high reset.
xgmii_txd  in  64  TX data; lane n is bits [8n+7:8n].
xgmii_txc  in  8  TX control flags, one per lane.
xgmii_rxd  out  64  RX data.
xgmii_rxc  out  8  RX control flags.
serdes_tx_data  out  64  encoded block payload; block type in [7:0].
serdes_tx_hdr  out  2  sync header: 2'b10 = data, 2'b01 = control.
serdes_rx_data  in  64  received payload.
serdes_rx_hdr  in  2  received sync header.
serdes_rx_bitslip  out  1  slip request to the SERDES.
rx_error_count  out  7  bad blocks counted in the current BER window.
rx_bad_block  out  1  1-cycle pulse per bad block.
rx_block_lock  out  1  block lock achieved.
rx_high_ber  out  1  high bit-error-rate flag.

Behaviour:
Reset values:
- serdes_tx_hdr = 01, serdes_tx_data = 64'h1E (idle block).
- xgmii_rxd = 64'h0707070707070707, xgmii_rxc = 8'hFF.
- All flags and counters = 0; lock state = unlocked.
Latency: TX is 1 registered cycle, RX is 1 registered cycle. There is no handshake; one block is processed per cycle.

TX encode:
- txc = 00: header 10, payload = txd.
- txc = 01 with lane0 = FB: header 01, type 0x78, [63:8] = txd[63:8].
- txc = 1F with lane4 = FB and lanes 0-3 = 07: header 01, type 0x33.
- Terminate at lane k (lane k = FD, lanes above k are control, lanes below k are data): type = {87,99,AA,B4,CC,D2,E1,FF}[k]. Data bytes are packed from bit 8 upward. Remaining 7-bit control codes are 0x00.
- txc = FF: type 0x1E, eight 7-bit codes, 07 -> 0x00 and any other character -> 0x1E.
- Any other pattern: error block, type 0x1E with all codes 0x1E.

RX decode: inverse of TX encode.
- Header 10: xgmii_rxd = payload, xgmii_rxc = 00.
- Terminate blocks: lanes after FD output 07.
- Bad block: header 00 or 11, unknown block type, or an invalid 7-bit code. Output is all lanes FE with rxc FF, and rx_bad_block pulses for 1 cycle.

Block lock FSM (checks valid headers 01/10):
- Unlocked: 64 consecutive valid headers set rx_block_lock.
- Unlocked, on any invalid header: pulse bitslip high for BITSLIP_HIGH_CYCLES, ignore headers for BITSLIP_LOW_CYCLES, then restart the count at 0.
- Locked: 16 invalid headers within a 64-header window clear lock, and the block issues a slip.

BER monitor:
- Free-running window counter of COUNT_125US cycles.
- Every invalid header increments the error counter, which saturates at 127.
- rx_high_ber is set when the count reaches 16 inside a window.
- At window end: rx_high_ber is re-evaluated from that window's count, then the count clears.

Scrambler (only when SCRAMBLER_DISABLE = 0):
- Scrambles the payload only, never the header.
- Descrambler state advances on every received block.

rst asserted mid-frame forces all reset values on the next edge.

Test Plan:
1. TX start: txd 64'hd5555555555555fb, txc 01 -> hdr 01, data 64'hd555555555555578 one cycle later.
2. TX data then terminate: txd 64'h000dddddaaaddddd, txc 00 -> hdr 10, same data. Then txd 64'hfd2233ee44eeefff, txc 80 -> hdr 01, data 64'h2233ee44eeefffff.
3. RX start: rx hdr 01, data 64'haaaaaaaaaaaaaa78 -> rxd 64'haaaaaaaaaaaaaafb, rxc 01. Then hdr 01, data 64'h87 -> rxd 64'h07070707070707fd, rxc FF.
4. RX idle: hdr 01, data 64'h1E -> rxd 64'h0707070707070707, rxc FF. Then hdr 11 -> rxd all FE, rxc FF, rx_bad_block pulse.
5. Lock: 64 valid headers -> rx_block_lock = 1. From unlocked, one header 00 -> bitslip high 1 cycle, then 8 cycles of headers ignored.
6. BER: 16 invalid headers within 19531 cycles -> rx_high_ber = 1 and rx_error_count = 16. A following clean window -> rx_high_ber = 0 and count = 0.
